// File: rtl/sdr_burst_streamer_if.sv
// Bus bundle of the burst streamer: SDR line-read handshake towards the bridge
// and the word stream towards the consumer.
interface sdr_burst_streamer_if #(
    parameter int LINE_W  = 2048,
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NELEM_W = 30
);
    logic                sdr_readstart;
    logic [ADDR_W-1:0]   sdr_baseaddr;
    logic [NELEM_W-1:0]  sdr_nelems;
    logic                sdr_readend;
    logic [LINE_W-1:0]   sdr_readdata;
    logic                out_valid;
    logic [WORD_W-1:0]   out_data;
    logic                out_ready;
    logic                out_last_word;
    logic                out_last;

    modport master (
        output sdr_readstart,
        output sdr_baseaddr,
        output sdr_nelems,
        input  sdr_readend,
        input  sdr_readdata,
        output out_valid,
        output out_data,
        output out_last_word,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  sdr_readstart,
        input  sdr_baseaddr,
        input  sdr_nelems,
        output sdr_readend,
        output sdr_readdata,
        input  out_valid,
        input  out_data,
        input  out_last_word,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sdr_burst_streamer.sv
// Reads a programmable number of wide SDR lines at strided addresses and
// streams each captured line out word by word, LSB word first.
module sdr_burst_streamer #(
    parameter int LINE_W  = 2048,
    parameter int WORD_W  = 32,
    parameter int ELEM_W  = 16,
    parameter int ADDR_W  = 32,
    parameter int NELEM_W = 30,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                              sdr_clk,
    input  logic                              sdr_reset_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [ADDR_W-1:0]                 base_addr,
    input  logic [ADDR_W-1:0]                 line_stride,
    input  logic [CNT_W-1:0]                  nlines,
    input  logic [$clog2(LINE_W/WORD_W):0]    words_per_line,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    sdr_burst_streamer_if.master              bus
);
    localparam int WORDS  = LINE_W / WORD_W;
    localparam int WPL_W  = $clog2(WORDS) + 1;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int EPW    = WORD_W / ELEM_W;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   stride_q;
    logic [WPL_W-1:0]    wpl_q;
    logic [CNT_W-1:0]    rem_q;
    logic [NELEM_W-1:0]  cfg_nel_q;
    logic [WPL_W-1:0]    idx_q;
    logic [31:0]         wait_cnt_q;
    logic [LINE_W-1:0]   line_q;
    logic                rd_start_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [NELEM_W-1:0]  rd_nelems_q;
    logic                valid_q;
    logic [WORD_W-1:0]   data_q;
    logic                last_word_q;
    logic                last_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                cfg_bad_d;
    logic [NELEM_W-1:0]  cfg_nelems_d;
    logic [WPL_W-1:0]    idx_inc_d;
    logic                idx_last_d;
    logic                next_last_word_d;
    logic                rem_last_d;
    logic [ADDR_W-1:0]   addr_nxt_d;
    logic [WORD_W-1:0]   next_word_d;
    logic                tmo_hit_d;

    // Configuration checks, next-word selection and timeout detection
    always_comb begin
        cfg_bad_d        = (nlines == CNT_W'(0)) || (words_per_line == WPL_W'(0))
                           || (words_per_line > WPL_W'(WORDS));
        cfg_nelems_d     = NELEM_W'(words_per_line) * NELEM_W'(EPW);
        idx_inc_d        = idx_q + WPL_W'(1);
        idx_last_d       = (idx_q == (wpl_q - WPL_W'(1)));
        next_last_word_d = (idx_inc_d == (wpl_q - WPL_W'(1)));
        rem_last_d       = (rem_q == CNT_W'(1));
        addr_nxt_d       = addr_q + stride_q;
        next_word_d      = line_q[WORD_W*idx_inc_d[IDX_W-1:0] +: WORD_W];
        tmo_hit_d        = TMO_EN && (wait_cnt_q == TMO_LAST);
    end

    // Sequencer: all outputs are registered and updated alongside the state
    always_ff @(posedge sdr_clk) begin
        if (!sdr_reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            stride_q    <= {ADDR_W{1'b0}};
            wpl_q       <= {WPL_W{1'b0}};
            rem_q       <= {CNT_W{1'b0}};
            cfg_nel_q   <= {NELEM_W{1'b0}};
            idx_q       <= {WPL_W{1'b0}};
            wait_cnt_q  <= 32'd0;
            line_q      <= {LINE_W{1'b0}};
            rd_start_q  <= 1'b0;
            rd_addr_q   <= {ADDR_W{1'b0}};
            rd_nelems_q <= {NELEM_W{1'b0}};
            valid_q     <= 1'b0;
            data_q      <= {WORD_W{1'b0}};
            last_word_q <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (abort) begin
            // Any outstanding read is abandoned; WAIT is left so its readend is ignored
            state_q     <= ST_IDLE;
            rd_start_q  <= 1'b0;
            rd_addr_q   <= {ADDR_W{1'b0}};
            rd_nelems_q <= {NELEM_W{1'b0}};
            valid_q     <= 1'b0;
            data_q      <= {WORD_W{1'b0}};
            last_word_q <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (cfg_bad_d) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            addr_q      <= base_addr;
                            stride_q    <= line_stride;
                            wpl_q       <= words_per_line;
                            rem_q       <= nlines;
                            cfg_nel_q   <= cfg_nelems_d;
                            done_q      <= 1'b0;
                            err_q       <= 1'b0;
                            busy_q      <= 1'b1;
                            rd_start_q  <= 1'b1;
                            rd_addr_q   <= base_addr;
                            rd_nelems_q <= cfg_nelems_d;
                            state_q     <= ST_REQ;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_REQ: begin
                    rd_start_q <= 1'b0;
                    wait_cnt_q <= 32'd0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.sdr_readend) begin
                        line_q      <= bus.sdr_readdata;
                        idx_q       <= {WPL_W{1'b0}};
                        valid_q     <= 1'b1;
                        data_q      <= bus.sdr_readdata[WORD_W-1:0];
                        last_word_q <= (wpl_q == WPL_W'(1));
                        last_q      <= (wpl_q == WPL_W'(1)) && rem_last_d;
                        rd_addr_q   <= {ADDR_W{1'b0}};
                        rd_nelems_q <= {NELEM_W{1'b0}};
                        state_q     <= ST_STREAM;
                    end else if (tmo_hit_d) begin
                        err_q       <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        rd_addr_q   <= {ADDR_W{1'b0}};
                        rd_nelems_q <= {NELEM_W{1'b0}};
                        state_q     <= ST_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                ST_STREAM: begin
                    if (bus.out_ready) begin
                        if (idx_last_d) begin
                            rem_q       <= rem_q - CNT_W'(1);
                            valid_q     <= 1'b0;
                            data_q      <= {WORD_W{1'b0}};
                            last_word_q <= 1'b0;
                            last_q      <= 1'b0;
                            if (!rem_last_d) begin
                                addr_q      <= addr_nxt_d;
                                rd_start_q  <= 1'b1;
                                rd_addr_q   <= addr_nxt_d;
                                rd_nelems_q <= cfg_nel_q;
                                state_q     <= ST_REQ;
                            end else begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_DONE;
                            end
                        end else begin
                            idx_q       <= idx_inc_d;
                            data_q      <= next_word_d;
                            last_word_q <= next_last_word_d;
                            last_q      <= next_last_word_d && rem_last_d;
                        end
                    end else begin
                        state_q <= ST_STREAM;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rd_start_q  <= 1'b0;
                    rd_addr_q   <= {ADDR_W{1'b0}};
                    rd_nelems_q <= {NELEM_W{1'b0}};
                    valid_q     <= 1'b0;
                    data_q      <= {WORD_W{1'b0}};
                    last_word_q <= 1'b0;
                    last_q      <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sdr_readstart = rd_start_q;
    assign bus.sdr_baseaddr  = rd_addr_q;
    assign bus.sdr_nelems    = rd_nelems_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_data      = data_q;
    assign bus.out_last_word = last_word_q;
    assign bus.out_last      = last_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
endmodule
